// File: rtl/serial_magnitude_cmp_pkg.sv
// Shared types and result codes for the bit-serial magnitude comparator.
package serial_cmp_pkg;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [1:0] CMP_LT = 2'd0;
   localparam logic [1:0] CMP_EQ = 2'd1;
   localparam logic [1:0] CMP_GT = 2'd2;

   localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/serial_magnitude_cmp_if.sv
// Request/result bundle of the serial comparator; is_signed exists only
// when SERIAL_CMP_SIGNED_EN is defined.
interface serial_magnitude_cmp_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_CMP_SIGNED_EN
   logic             is_signed;
`endif
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (
      output start, a, b,
`ifdef SERIAL_CMP_SIGNED_EN
      output is_signed,
`endif
      input  busy, done, gt, eq, lt
   );

   modport slave (
      input  start, a, b,
`ifdef SERIAL_CMP_SIGNED_EN
      input  is_signed,
`endif
      output busy, done, gt, eq, lt
   );
endinterface

// File: rtl/serial_magnitude_cmp_bit_cell.sv
// One-bit compare decision; sign_step flips the sense for a two's complement sign bit.
module cmp_bit_cell (
   input  logic x,
   input  logic y,
   input  logic sign_step,
   output logic differ,
   output logic a_gt
);
   assign differ = x ^ y;
   assign a_gt   = sign_step ? (~x & y) : (x & ~y);
endmodule

// File: rtl/serial_magnitude_cmp.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake and early exit.
// Optional signed mode: define SERIAL_CMP_SIGNED_EN.
module serial_magnitude_cmp
   import serial_cmp_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_magnitude_cmp_if.slave bus
);
   state_t           state, state_n;
   logic [WIDTH-1:0] sa, sa_n, sb, sb_n;
   logic [CNT_W-1:0] idx, idx_n;
   logic             busy_q, busy_n, done_q, done_n;
   logic             gt_q, gt_n, eq_q, eq_n, lt_q, lt_n;
   logic             sign_step, differ, a_gt;

`ifdef SERIAL_CMP_SIGNED_EN
   logic sgn_q, sgn_n;
   assign sign_step = sgn_q && (idx == CNT_W'(WIDTH-1));
`else
   assign sign_step = 1'b0;
`endif

   cmp_bit_cell u_cell (
      .x        (sa[WIDTH-1]),
      .y        (sb[WIDTH-1]),
      .sign_step(sign_step),
      .differ   (differ),
      .a_gt     (a_gt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         idx    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         gt_q   <= 1'b0;
         eq_q   <= 1'b0;
         lt_q   <= 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
         sgn_q  <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         sa     <= sa_n;
         sb     <= sb_n;
         idx    <= idx_n;
         busy_q <= busy_n;
         done_q <= done_n;
         gt_q   <= gt_n;
         eq_q   <= eq_n;
         lt_q   <= lt_n;
`ifdef SERIAL_CMP_SIGNED_EN
         sgn_q  <= sgn_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      sa_n    = sa;
      sb_n    = sb;
      idx_n   = idx;
      busy_n  = busy_q;
      done_n  = 1'b0;
      gt_n    = gt_q;
      eq_n    = eq_q;
      lt_n    = lt_q;
`ifdef SERIAL_CMP_SIGNED_EN
      sgn_n   = sgn_q;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
               sa_n    = bus.a;
               sb_n    = bus.b;
               idx_n   = CNT_W'(WIDTH-1);
               busy_n  = 1'b1;
               gt_n    = 1'b0;
               eq_n    = 1'b0;
               lt_n    = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
               sgn_n   = bus.is_signed;
`endif
               state_n = RUN;
            end
         end
         RUN: begin
            if (differ) begin
               gt_n    = a_gt;
               lt_n    = ~a_gt;
               eq_n    = 1'b0;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else if (idx == '0) begin
               gt_n    = 1'b0;
               lt_n    = 1'b0;
               eq_n    = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end else begin
               sa_n  = {sa[WIDTH-2:0], 1'b0};
               sb_n  = {sb[WIDTH-2:0], 1'b0};
               idx_n = idx - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.gt   = gt_q;
   assign bus.eq   = eq_q;
   assign bus.lt   = lt_q;
endmodule
